vr_vc_converter: RTL and testbench

- Valid/ready to valid/credit converter; the upstream stage that feeds the valid/credit to valid/ready receiver.
- Accepts beats from a valid/ready producer and forwards them over a valid/credit link, one registered stage of latency.
- Tracks remaining receiver buffer space with a credit counter. Credits are loaded by the receiver's post-reset credit pulses and returned one per popped beat.

---
 rtl/vc_pkg.sv | 14 +
 rtl/vr_vc_converter.sv | 93 +++++++++
 tb/tb_vr_vc_converter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vc_pkg.sv
// Shared helpers for the valid/credit link converters.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vc_pkg;

    // Receiver buffer depth used when an instance does not override it.
    localparam int DEFAULT_CREDIT_NUM = 2;

    // Bits needed for a counter that must hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit converter: forwards accepted beats over a credit link.
// Latency: one registered stage; an accepted beat appears on m_valid_o the next cycle.
// Backpressure: s_ready_o is low while no receiver credits remain; credits re-open it one cycle later.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   s_data_i/s_valid_i   upstream payload and valid
//   s_ready_o            high while at least one credit is held
//   m_data_o/m_valid_o   downstream payload and single-cycle beat strobe
//   m_credit_i           single-cycle credit return from the receiver
//   credit_cnt_o         credits currently available
//   idle_o               all credits home and no beat on the output
//   credit_ovf_o         sticky flag: a credit arrived while the counter was full
module vr_vc_converter
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CREDIT_NUM   = DEFAULT_CREDIT_NUM,
    parameter int INIT_CREDITS = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [DATA_WIDTH-1:0]            s_data_i,
    input  logic                             s_valid_i,
    output logic                             s_ready_o,
    output logic [DATA_WIDTH-1:0]            m_data_o,
    output logic                             m_valid_o,
    input  logic                             m_credit_i,
    output logic [cnt_width(CREDIT_NUM)-1:0] credit_cnt_o,
    output logic                             idle_o,
    output logic                             credit_ovf_o
);

    localparam int            CW       = cnt_width(CREDIT_NUM);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CREDIT_NUM);
    localparam logic [CW-1:0] CNT_INIT = CW'(INIT_CREDITS);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          ovf_nxt;
    logic          send;

    // Ready comes only from the registered count, so a returning credit
    // cannot reach s_ready_o in the same cycle it arrives.
    assign s_ready_o = (cnt != '0);
    assign send      = s_valid_i && s_ready_o;

    // Credit accounting. A send always has cnt >= 1, so the decrement
    // cannot wrap; a credit with a simultaneous send is a net no-op.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = credit_ovf_o;
        case ({m_credit_i, send})
            2'b10: begin
                if (cnt == CNT_MAX) begin
                    // Receiver returned more credits than it owns.
                    ovf_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= CNT_INIT;
            credit_ovf_o <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            credit_ovf_o <= ovf_nxt;
        end
    end

    // Output stage: one strobe per accepted beat; data holds between beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
        end else begin
            m_valid_o <= send;
            if (send) begin
                m_data_o <= s_data_i;
            end
        end
    end

    assign credit_cnt_o = cnt;
    assign idle_o       = (cnt == CNT_MAX) && !m_valid_o;

endmodule

// File: tb/tb_vr_vc_converter.sv
// Bench for vr_vc_converter: directed vectors plus a loopback against a receiver model.
// Latency: n/a.
// Backpressure: receiver model drives random ready and returns one credit per popped beat.
module tb_vr_vc_converter;

    localparam int CN2 = 2;
    localparam int CN4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DUT A: CREDIT_NUM = 2 ----------------
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_credit = 1'b0;
    logic [1:0] cnt;
    logic       idle;
    logic       ovf;

    vr_vc_converter #(.DATA_WIDTH(8), .CREDIT_NUM(CN2), .INIT_CREDITS(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_credit_i(m_credit),
        .credit_cnt_o(cnt), .idle_o(idle), .credit_ovf_o(ovf)
    );

    // ---------------- DUT B: CREDIT_NUM = 4 (loopback) ----------------
    logic       rst4_n = 1'b0;
    logic [7:0] s_data4 = 8'h00;
    logic       s_valid4 = 1'b0;
    logic       s_ready4;
    logic [7:0] m_data4;
    logic       m_valid4;
    logic       m_credit4 = 1'b0;
    logic [2:0] cnt4;
    logic       idle4;
    logic       ovf4;

    vr_vc_converter #(.DATA_WIDTH(8), .CREDIT_NUM(CN4), .INIT_CREDITS(0)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .s_data_i(s_data4), .s_valid_i(s_valid4), .s_ready_o(s_ready4),
        .m_data_o(m_data4), .m_valid_o(m_valid4), .m_credit_i(m_credit4),
        .credit_cnt_o(cnt4), .idle_o(idle4), .credit_ovf_o(ovf4)
    );

    // ---------------- Behavioural model of DUT A ----------------
    // Credits are a plain integer clamped to CN2; a beat is accepted when any credit
    // is held and shows up as the output of the following cycle.
    int         md_cnt;
    bit         md_ovf;
    bit         md_vld;
    logic [7:0] md_dat;
    bit         md_acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt = 0;
            md_ovf = 1'b0;
            md_vld = 1'b0;
            md_dat = 8'h00;
        end else begin
            md_acc = s_valid && (md_cnt > 0);
            if (m_credit && !md_acc && md_cnt == CN2) md_ovf = 1'b1;
            md_vld = md_acc;
            if (md_acc) md_dat = s_data;
            md_cnt = md_cnt + (m_credit ? 1 : 0) - (md_acc ? 1 : 0);
            if (md_cnt > CN2) md_cnt = CN2;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_cnt",   32'(cnt),     32'(md_cnt));
            chk("model_ready", 32'(s_ready), 32'(md_cnt > 0));
            chk("model_valid", 32'(m_valid), 32'(md_vld));
            chk("model_data",  32'(m_data),  32'(md_dat));
            chk("model_ovf",   32'(ovf),     32'(md_ovf));
            chk("model_idle",  32'(idle),    32'((md_cnt == CN2) && !md_vld));
        end
    end

    // ---------------- Loopback with a receiver model ----------------
    task automatic loopback();
        logic [7:0] rxq[$];
        logic [7:0] expq[$];
        logic [7:0] got;
        int  owed     = 0;
        int  sent     = 0;
        int  sent_pre = 0;
        int  rcvd     = 0;
        int  rcvd_pre = 0;
        int  cyc      = 0;
        bit  rst_done = 1'b0;
        bit  done     = 1'b0;

        rst4_n = 1'b0;
        tick();
        tick();
        rst4_n = 1'b1;
        owed = CN4;
        while (cyc < 20000) begin
            cyc++;
            if (sent == 1000 && rxq.size() == 0 && expq.size() == 0 && owed == 0 && !m_valid4) begin
                done = 1'b1;
                break;
            end
            if (sent >= 500 && !rst_done) begin
                // Both link ends reset together; anything in flight is lost.
                rst_done  = 1'b1;
                rst4_n    = 1'b0;
                s_valid4  = 1'b0;
                m_credit4 = 1'b0;
                #1;
                chk("lb_rst_valid", 32'(m_valid4), 32'd0);
                chk("lb_rst_cnt",   32'(cnt4),     32'd0);
                chk("lb_rst_ready", 32'(s_ready4), 32'd0);
                chk("lb_pre_rcvd_nonzero", 32'(rcvd > 0), 32'd1);
                rxq.delete();
                expq.delete();
                rcvd_pre = rcvd;
                sent_pre = sent;
                tick();
                rst4_n = 1'b1;
                owed = CN4;
                tick();
            end
            // receiver pops first, then captures the beat on the link this cycle
            if (rxq.size() > 0 && $urandom_range(0, 9) < 6) begin
                got = rxq.pop_front();
                rcvd++;
                owed++;
                chk("lb_exp_nonempty", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) chk("lb_order", 32'(got), 32'(expq.pop_front()));
            end
            if (m_valid4) begin
                rxq.push_back(m_data4);
                chk("lb_rx_occupancy", 32'(rxq.size() <= CN4), 32'd1);
            end
            m_credit4 = (owed > 0);
            if (owed > 0) owed--;
            // producer: s_ready4 is registered-only, so it already holds its value at the next edge
            if (sent < 1000 && $urandom_range(0, 9) < 7) begin
                s_valid4 = 1'b1;
                s_data4  = 8'($urandom);
                if (s_ready4) begin
                    expq.push_back(s_data4);
                    sent++;
                end
            end else begin
                s_valid4 = 1'b0;
            end
            chk("lb_ovf", 32'(ovf4), 32'd0);
            tick();
        end
        m_credit4 = 1'b0;
        s_valid4  = 1'b0;
        chk("lb_drain_in_time", 32'(done), 32'd1);
        tick();
        tick();
        chk("lb_delivered", 32'(rcvd - rcvd_pre), 32'(sent - sent_pre));
        chk("lb_final_cnt",  32'(cnt4),  32'(CN4));
        chk("lb_final_idle", 32'(idle4), 32'd1);
        chk("lb_final_ovf",  32'(ovf4),  32'd0);
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        tick();
        tick();
        chk("rst_cnt",   32'(cnt),     32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data",  32'(m_data),  32'd0);
        chk("rst_ovf",   32'(ovf),     32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_idle",  32'(idle),    32'd0);
        rst_n  = 1'b1;
        rst4_n = 1'b1;

        // initial credit pulses
        tick();
        m_credit = 1'b1;
        tick();
        chk("init_cnt1",  32'(cnt),     32'd1);
        chk("init_ready", 32'(s_ready), 32'd1);
        tick();
        m_credit = 1'b0;
        chk("init_cnt2", 32'(cnt),  32'd2);
        chk("init_idle", 32'(idle), 32'd1);

        // two back-to-back beats drain both credits; third is held off
        s_valid = 1'b1;
        s_data  = 8'hA1;
        tick();
        chk("b2b_valid1", 32'(m_valid), 32'd1);
        chk("b2b_data1",  32'(m_data),  32'hA1);
        chk("b2b_cnt1",   32'(cnt),     32'd1);
        s_data = 8'hA2;
        tick();
        chk("b2b_valid2", 32'(m_valid), 32'd1);
        chk("b2b_data2",  32'(m_data),  32'hA2);
        chk("b2b_cnt0",   32'(cnt),     32'd0);
        chk("b2b_ready0", 32'(s_ready), 32'd0);
        s_data = 8'hA3;
        tick();
        chk("held_valid", 32'(m_valid), 32'd0);
        chk("held_data",  32'(m_data),  32'hA2);
        tick();
        chk("held_valid2", 32'(m_valid), 32'd0);

        // credit at cnt 0 reopens ready only in the next cycle
        m_credit = 1'b1;
        chk("cred_same_cycle_ready", 32'(s_ready), 32'd0);
        tick();
        m_credit = 1'b0;
        chk("cred_ready_next", 32'(s_ready), 32'd1);
        chk("cred_no_valid",   32'(m_valid), 32'd0);
        tick();
        s_valid = 1'b0;
        chk("a3_valid", 32'(m_valid), 32'd1);
        chk("a3_data",  32'(m_data),  32'hA3);
        chk("a3_cnt",   32'(cnt),     32'd0);

        // cnt 1: send and credit together
        m_credit = 1'b1;
        tick();
        chk("pre_cnt1", 32'(cnt), 32'd1);
        s_valid = 1'b1;
        s_data  = 8'hB4;
        tick();
        s_valid  = 1'b0;
        m_credit = 1'b0;
        chk("both_cnt",   32'(cnt),     32'd1);
        chk("both_valid", 32'(m_valid), 32'd1);
        chk("both_data",  32'(m_data),  32'hB4);
        tick();
        chk("both_single_pulse", 32'(m_valid), 32'd0);

        // full counter: send+credit is not an overflow, a lone credit is
        m_credit = 1'b1;
        tick();
        chk("full_cnt", 32'(cnt), 32'd2);
        s_valid = 1'b1;
        s_data  = 8'hC5;
        tick();
        s_valid = 1'b0;
        chk("full_both_cnt", 32'(cnt), 32'd2);
        chk("full_both_ovf", 32'(ovf), 32'd0);
        tick();
        m_credit = 1'b0;
        chk("ovf_cnt_sat", 32'(cnt), 32'd2);
        chk("ovf_set",     32'(ovf), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("ovf_sticky", 32'(ovf), 32'd1);

        // asynchronous reset with a beat on the output
        s_valid = 1'b1;
        s_data  = 8'hD6;
        tick();
        chk("mid_valid_before", 32'(m_valid), 32'd1);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_cnt",   32'(cnt),     32'd0);
        chk("mid_rst_ovf",   32'(ovf),     32'd0);
        chk("mid_rst_data",  32'(m_data),  32'd0);
        tick();
        rst_n = 1'b1;

        // random traffic on DUT A, checked by the model every cycle
        for (int i = 0; i < 300; i++) begin
            s_valid  = 1'($urandom_range(0, 1));
            s_data   = 8'($urandom);
            m_credit = ($urandom_range(0, 2) == 0);
            tick();
        end
        s_valid  = 1'b0;
        m_credit = 1'b0;

        loopback();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
